// File: rtl/ed25519_point_decompress_if.sv
// ---------------------------------------------------------------------------
// ed25519_point_decompress_if
//   Handshake bundle for the Ed25519 point decompressor.
//   in_valid/in_ready/enc    : request channel, 256-bit compressed encoding
//   out_valid/out_ready      : response channel, result held until accepted
//   X, Y, Z, T               : extended Edwards coordinates, reduced mod p
//   err                      : encoding invalid (qualified by out_valid)
//   modport slave  : the decompressor
//   modport master : the producer/consumer driving it
// ---------------------------------------------------------------------------
interface ed25519_point_decompress_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] enc;
  logic         out_valid;
  logic         out_ready;
  logic [254:0] X;
  logic [254:0] Y;
  logic [254:0] Z;
  logic [254:0] T;
  logic         err;

  modport master (
    output in_valid, enc, out_ready,
    input  in_ready, out_valid, X, Y, Z, T, err
  );

  modport slave (
    input  in_valid, enc, out_ready,
    output in_ready, out_valid, X, Y, Z, T, err
  );
endinterface

// File: rtl/ed25519_point_decompress.sv
// ---------------------------------------------------------------------------
// ed25519_point_decompress
//   Decodes a 32-byte compressed Ed25519 point into extended coordinates
//   (X, Y, Z=1, T=XY). A single time-shared multiplier mod p = 2^255-19 runs
//   a fixed 514-step program, 3 cycles per step, so every input (valid or
//   not) takes exactly 1543 cycles from the accepting edge to out_valid.
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset (aborts any decode in flight)
//     bus   : ed25519_point_decompress_if.slave (request/response handshake)
// ---------------------------------------------------------------------------
module ed25519_point_decompress (
  input  logic                             clk,
  input  logic                             rst_n,
  ed25519_point_decompress_if.slave        bus
);

  localparam logic [255:0] P_256 =
    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [255:0] D_256 =
    256'h52036cee_2b6ffe73_8cc74079_7779e898_00700a4d_4141d8ab_75eb4dca_135978a3;
  localparam logic [255:0] SQRTM1_256 =
    256'h2b832480_4fc1df0b_2b4d0099_3dfbd7a7_2f431806_ad2fe478_c4ee1b27_4a0ea0b0;

  localparam logic [254:0] P      = P_256[254:0];
  localparam logic [254:0] D      = D_256[254:0];
  localparam logic [254:0] SQRTM1 = SQRTM1_256[254:0];

  localparam logic [9:0] LAST_STEP = 10'd513;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FINAL, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [9:0]    r_step;
  logic [1:0]    r_phase;
  logic          w_accept;
  logic          w_last;
  logic          w_in_ready;
  logic          w_out_valid;

  // Latched request
  logic [254:0]  r_y;
  logic          r_s;
  logic          r_yerr;

  // Intermediates of the multiply program
  logic [254:0]  r_y2, r_u, r_v, r_v2, r_v3, r_v6, r_v7;
  logic [254:0]  r_uv3, r_uv7, r_acc;
  logic [254:0]  r_x, r_xs, r_x2, r_vx2, r_xf, r_t;
  logic          r_nerr, r_zerr;

  // Multiplier pipeline
  logic [254:0]  r_a, r_b;
  logic [509:0]  r_prod;
  logic [254:0]  w_op_a, w_op_b;
  logic [259:0]  w_s1;
  logic [9:0]    w_c19;
  logic [255:0]  w_s2;
  logic [254:0]  w_red;
  logic [254:0]  w_red_m1, w_red_p1;

  // Exponent ladder / root selection
  logic [9:0]    w_k;
  logic          w_exp_mul;
  logic [254:0]  w_neg_u, w_xr, w_xf;
  logic          w_pos, w_neg, w_nerr, w_zerr, w_err;

  // Result registers
  logic [254:0]  r_x_out, r_y_out, r_t_out;
  logic          r_err;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_last   = (r_phase == 2'd2) && (r_step == LAST_STEP);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: every clocked process assigns with <= so all registers see the
  // values from before the edge, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next-state logic
  // NOTE: combinational processes assign a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)  w_next = S_MUL;
      S_MUL:   if (w_last)        w_next = S_FINAL;
      S_FINAL:                    w_next = S_HOLD;
      S_HOLD:  if (bus.out_ready) w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready  = 1'b1;
      S_HOLD:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Step sequencer: phase 0 latches operands, 1 multiplies, 2 reduces.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step  <= '0;
      r_phase <= '0;
    end else if (w_accept) begin
      r_step  <= '0;
      r_phase <= '0;
    end else if (r_state == S_MUL) begin
      if (r_phase == 2'd2) begin
        r_phase <= 2'd0;
        r_step  <= r_step + 10'd1;
      end else begin
        r_phase <= r_phase + 2'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Exponent ladder for uv7^(2^252-3). Steps 8..508 map to k = 0..500:
  // bits 250..2 take a square then a multiply (k even / odd below 498),
  // bit 1 is square only (k=498), bit 0 squares (k=499) then multiplies.
  // -------------------------------------------------------------------------
  assign w_k       = r_step - 10'd8;
  assign w_exp_mul = ((w_k < 10'd498) && w_k[0]) || (w_k == 10'd500);

  // Operand selection for the current step
  always_comb begin
    w_op_a = r_acc;
    w_op_b = r_acc;
    case (r_step)
      10'd0:   begin w_op_a = r_y;   w_op_b = r_y;    end
      10'd1:   begin w_op_a = D;     w_op_b = r_y2;   end
      10'd2:   begin w_op_a = r_v;   w_op_b = r_v;    end
      10'd3:   begin w_op_a = r_v2;  w_op_b = r_v;    end
      10'd4:   begin w_op_a = r_v3;  w_op_b = r_v3;   end
      10'd5:   begin w_op_a = r_v6;  w_op_b = r_v;    end
      10'd6:   begin w_op_a = r_u;   w_op_b = r_v3;   end
      10'd7:   begin w_op_a = r_u;   w_op_b = r_v7;   end
      10'd509: begin w_op_a = r_uv3; w_op_b = r_acc;  end
      10'd510: begin w_op_a = r_x;   w_op_b = SQRTM1; end
      10'd511: begin w_op_a = r_x;   w_op_b = r_x;    end
      10'd512: begin w_op_a = r_v;   w_op_b = r_x2;   end
      10'd513: begin w_op_a = w_xf;  w_op_b = r_y;    end
      default: if (w_exp_mul) w_op_b = r_uv7;
    endcase
  end

  // -------------------------------------------------------------------------
  // Fold reduction: 2^255 == 19 (mod p). Two folds bring the product below
  // 2p, then one conditional subtract lands it in [0, p).
  // -------------------------------------------------------------------------
  assign w_s1  = {5'd0, r_prod[254:0]}
               + {1'b0, r_prod[509:255], 4'd0}
               + {4'd0, r_prod[509:255], 1'b0}
               + {5'd0, r_prod[509:255]};
  assign w_c19 = {1'b0, w_s1[259:255], 4'd0}
               + {4'd0, w_s1[259:255], 1'b0}
               + {5'd0, w_s1[259:255]};
  assign w_s2  = {1'b0, w_s1[254:0]} + {246'd0, w_c19};
  // The subtracted result is below p, so the low 255 bits are exact.
  assign w_red = (w_s2 >= {1'b0, P}) ? (w_s2[254:0] - P) : w_s2[254:0];

  // Wrapping +/-1 used for v = d*y^2 + 1 and u = y^2 - 1
  assign w_red_m1 = (w_red == '0)           ? (P - 255'd1) : (w_red - 255'd1);
  assign w_red_p1 = (w_red == (P - 255'd1)) ? '0           : (w_red + 255'd1);

  // -------------------------------------------------------------------------
  // Root selection and sign fix, evaluated from vx2 before the last step.
  // If neither candidate matches, xr is a don't-care and nerr flags it.
  // -------------------------------------------------------------------------
  assign w_neg_u = (r_u == '0) ? '0 : (P - r_u);
  assign w_pos   = (r_vx2 == r_u);
  assign w_neg   = (r_vx2 == w_neg_u);
  assign w_xr    = w_pos ? r_x : r_xs;
  assign w_nerr  = !w_pos && !w_neg;
  assign w_zerr  = (w_xr == '0) && r_s;
  assign w_xf    = (w_xr[0] != r_s) ? ((w_xr == '0) ? '0 : (P - w_xr)) : w_xr;
  assign w_err   = r_yerr | r_nerr | r_zerr;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the datapath has no reset: each register is written by the
  // program before it is read in every decode, and a reset mid-decode
  // returns the FSM to IDLE so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_y    <= bus.enc[254:0];
      r_s    <= bus.enc[255];
      r_yerr <= (bus.enc[254:0] >= P);
    end
    if (r_state == S_MUL) begin
      case (r_phase)
        2'd0: begin
          r_a <= w_op_a;
          r_b <= w_op_b;
          if (r_step == LAST_STEP) begin
            r_xf   <= w_xf;
            r_nerr <= w_nerr;
            r_zerr <= w_zerr;
          end
        end
        2'd1: r_prod <= {255'd0, r_a} * {255'd0, r_b};
        2'd2: begin
          case (r_step)
            10'd0: begin
              r_y2 <= w_red;
              r_u  <= w_red_m1;
            end
            10'd1:   r_v   <= w_red_p1;
            10'd2:   r_v2  <= w_red;
            10'd3:   r_v3  <= w_red;
            10'd4:   r_v6  <= w_red;
            10'd5:   r_v7  <= w_red;
            10'd6:   r_uv3 <= w_red;
            10'd7: begin
              r_uv7 <= w_red;
              r_acc <= w_red;   // accumulator starts at uv7 (exponent bit 251)
            end
            10'd509: r_x   <= w_red;
            10'd510: r_xs  <= w_red;
            10'd511: r_x2  <= w_red;
            10'd512: r_vx2 <= w_red;
            10'd513: r_t   <= w_red;
            default: r_acc <= w_red;  // exponent ladder steps 8..508
          endcase
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Result registers, loaded in FINAL; failures report the identity point.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_out <= '0;
      r_y_out <= 255'd1;
      r_t_out <= '0;
      r_err   <= 1'b0;
    end else if (r_state == S_FINAL) begin
      r_err   <= w_err;
      r_x_out <= w_err ? '0     : r_xf;
      r_y_out <= w_err ? 255'd1 : r_y;
      r_t_out <= w_err ? '0     : r_t;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.X         = r_x_out;
  assign bus.Y         = r_y_out;
  assign bus.Z         = 255'd1;
  assign bus.T         = r_t_out;
  assign bus.err       = r_err;

endmodule
